// File: rtl/pool_pkg.sv
// ============================================================================
// Module      : pool_pkg
// Description : Shared defaults, FSM state type and index/offset helpers for
//               the pooled-frame buffer.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package pool_pkg;

    localparam int DEF_DW   = 8;
    localparam int DEF_CH   = 3;
    localparam int DEF_ROWS = 3;
    localparam int DEF_COLS = 3;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } fill_state_t;

    // Index width that never collapses to zero bits for a 1-deep dimension
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Element index of (ch,r,c) inside the flat frame vector, in DW units
    function automatic int elem_off(input int ch, input int r, input int c,
                                    input int rows, input int cols);
        return ch * rows * cols + r * cols + c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pool_frame_bank.sv
// ============================================================================
// Module      : pool_frame_bank
// Description : One frame of pooled results stored as a flat register vector.
//               A write stores all CH lanes at one (row,col) position.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module pool_frame_bank
    import pool_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CH   = DEF_CH,
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic [clog2_min1(ROWS)-1:0]      row,
    input  logic [clog2_min1(COLS)-1:0]      col,
    input  logic [CH*DW-1:0]                 data,
    output logic [CH*ROWS*COLS*DW-1:0]       frame
);

    localparam int RW = clog2_min1(ROWS);
    localparam int CW = clog2_min1(COLS);

    for (genvar k = 0; k < CH; k++) begin : g_ch
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            for (genvar c = 0; c < COLS; c++) begin : g_col
                localparam int OFF = elem_off(k, r, c, ROWS, COLS);
                logic [DW-1:0] q;

                // Element register: loads lane k when its (row,col) is addressed
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q <= '0;
                    end else if (we && (row == RW'(r)) && (col == CW'(c))) begin
                        q <= data[k*DW +: DW];
                    end
                end

                assign frame[OFF*DW +: DW] = q;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pool_frame_buf.sv
// ============================================================================
// Module      : pool_frame_buf
// Description : Collects CH-lane pooled results one position per beat and
//               presents the completed ROWS x COLS x CH frame with valid/ready.
//               Optional ping-pong banking enabled by POOL_FRAME_PINGPONG_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module pool_frame_buf
    import pool_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CH   = DEF_CH,
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_vld,
    output logic                             in_rdy,
    input  logic [CH*DW-1:0]                 in_data,
    output logic [clog2_min1(ROWS)-1:0]      wr_row,
    output logic [clog2_min1(COLS)-1:0]      wr_col,
    output logic                             frame_vld,
    input  logic                             frame_rdy,
    output logic [CH*ROWS*COLS*DW-1:0]       frame_lin
);

    localparam int RW = clog2_min1(ROWS);
    localparam int CW = clog2_min1(COLS);
    localparam int FW = CH * ROWS * COLS * DW;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    fill_state_t state;
    logic        accept;
    logic        last;

    // FULL means the fill side is stalled; that is the only reason to refuse
    assign in_rdy = (state == ST_FILL);
    assign accept = in_vld && in_rdy && !flush;
    assign last   = (wr_row == LAST_ROW) && (wr_col == LAST_COL);

`ifdef POOL_FRAME_PINGPONG_EN
    logic          fill_ptr;
    logic [FW-1:0] frame0;
    logic [FW-1:0] frame1;

    // Fill/index/presentation control with a bank pointer; output bank is ~fill_ptr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            wr_row    <= '0;
            wr_col    <= '0;
            frame_vld <= 1'b0;
            fill_ptr  <= 1'b0;
        end else if (flush) begin
            // Drop fill progress (including a waiting bank) but keep the presented frame
            state  <= ST_FILL;
            wr_row <= '0;
            wr_col <= '0;
            if (frame_vld && frame_rdy) begin
                frame_vld <= 1'b0;
            end
        end else begin
            if (accept) begin
                if (last) begin
                    wr_row <= '0;
                    wr_col <= '0;
                end else if (wr_col == LAST_COL) begin
                    wr_col <= '0;
                    wr_row <= wr_row + RW'(1);
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end
            if (state == ST_FILL) begin
                if (accept && last) begin
                    if (!frame_vld || frame_rdy) begin
                        fill_ptr  <= ~fill_ptr;
                        frame_vld <= 1'b1;
                    end else begin
                        state <= ST_FULL;
                    end
                end else if (frame_vld && frame_rdy) begin
                    frame_vld <= 1'b0;
                end
            end else if (frame_rdy) begin
                // Waiting bank becomes the presented one; frame_vld stays high
                fill_ptr <= ~fill_ptr;
                state    <= ST_FILL;
            end
        end
    end

    pool_frame_bank #(.DW(DW), .CH(CH), .ROWS(ROWS), .COLS(COLS)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && (fill_ptr == 1'b0)),
        .row   (wr_row),
        .col   (wr_col),
        .data  (in_data),
        .frame (frame0)
    );

    pool_frame_bank #(.DW(DW), .CH(CH), .ROWS(ROWS), .COLS(COLS)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && (fill_ptr == 1'b1)),
        .row   (wr_row),
        .col   (wr_col),
        .data  (in_data),
        .frame (frame1)
    );

    assign frame_lin = fill_ptr ? frame0 : frame1;
`else
    // Fill/index/presentation control for the single-bank build
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            wr_row    <= '0;
            wr_col    <= '0;
            frame_vld <= 1'b0;
        end else if (flush) begin
            state     <= ST_FILL;
            wr_row    <= '0;
            wr_col    <= '0;
            frame_vld <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    wr_row <= '0;
                    wr_col <= '0;
                end else if (wr_col == LAST_COL) begin
                    wr_col <= '0;
                    wr_row <= wr_row + RW'(1);
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end
            case (state)
                ST_FILL: begin
                    if (accept && last) begin
                        state     <= ST_FULL;
                        frame_vld <= 1'b1;
                    end
                end
                default: begin
                    if (frame_rdy) begin
                        state     <= ST_FILL;
                        frame_vld <= 1'b0;
                    end
                end
            endcase
        end
    end

    pool_frame_bank #(.DW(DW), .CH(CH), .ROWS(ROWS), .COLS(COLS)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .row   (wr_row),
        .col   (wr_col),
        .data  (in_data),
        .frame (frame_lin)
    );
`endif

endmodule

`default_nettype wire
